// File: rtl/hitw_pkg.sv
// Shared types for the approaching-wall generator: FSM states, hole rectangle
// record and the saturating depth helper.
package hitw_pkg;

  localparam int HOLE_W = 11;  // horizontal coordinate width
  localparam int HOLE_H = 10;  // vertical coordinate width

  typedef enum logic [1:0] {
    IDLE,
    APPROACH,
    HIT,
    DONE
  } wall_state_t;

  typedef struct packed {
    logic [HOLE_W-1:0] x0;
    logic [HOLE_W-1:0] x1;
    logic [HOLE_H-1:0] y0;
    logic [HOLE_H-1:0] y1;
  } hole_rect_t;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? 8'd0 : a - b;
  endfunction

endpackage

// File: rtl/hole_rom.sv
// Hole shape table: maps the latched hole index to a half-open rectangle
// [x0,x1) x [y0,y1) in screen coordinates.
module hole_rom
  import hitw_pkg::*;
(
  input  logic [1:0] sel,
  output hole_rect_t rect
);

  always_comb begin
    case (sel)
      2'd0:    rect = '{x0: 11'd512, x1: 11'd768,  y0: 10'd200, y1: 10'd520};
      2'd1:    rect = '{x0: 11'd200, x1: 11'd1080, y0: 10'd500, y1: 10'd700};
      2'd2:    rect = '{x0: 11'd560, x1: 11'd720,  y0: 10'd0,   y1: 10'd720};
      default: rect = '{x0: 11'd100, x1: 11'd400,  y0: 10'd100, y1: 10'd400};
    endcase
  end

endmodule

// File: rtl/wall_generator.sv
// One round of an approaching wall with a selectable hole. Depth steps down
// on frame boundaries only; pixel outputs come out of a 2-stage pipeline.
module wall_generator
  import hitw_pkg::*;
#(
  parameter int          ACTIVE_H_PIXELS = 1280,
  parameter int          ACTIVE_LINES    = 720,
  parameter logic [7:0]  START_DEPTH     = 8'd255,
  parameter int          STEP_FRAMES     = 4,
  parameter logic [7:0]  DEPTH_STEP      = 8'd2,
  parameter logic [15:0] WALL_NEAR_COLOR = 16'hF800,
  parameter logic [15:0] WALL_FAR_COLOR  = 16'h7800
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [HOLE_W-1:0]  h_count_in,
  input  logic [HOLE_H-1:0]  v_count_in,
  input  logic               new_frame_in,
  input  logic               start_in,
  input  logic [1:0]         hole_sel_in,
  input  logic [7:0]         player_depth_in,
  output logic [HOLE_W-1:0]  hcount_out,
  output logic [HOLE_H-1:0]  vcount_out,
  output logic               is_wall,
  output logic [15:0]        wall_color,
  output logic [7:0]         wall_depth,
  output logic               round_active,
  output logic               wall_hit
);

  localparam int                FW         = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FW-1:0]     LAST_FRAME = FW'(STEP_FRAMES - 1);
  localparam logic [HOLE_W-1:0] H_LIMIT    = HOLE_W'(ACTIVE_H_PIXELS);
  localparam logic [HOLE_H-1:0] V_LIMIT    = HOLE_H'(ACTIVE_LINES);

  wall_state_t   state, next_state;
  logic [7:0]    depth, next_depth;
  logic [FW-1:0] frame_cnt, next_frame_cnt;
  logic [1:0]    hole_sel, next_hole_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      depth     <= '0;
      frame_cnt <= '0;
      hole_sel  <= '0;
    end else begin
      state     <= next_state;
      depth     <= next_depth;
      frame_cnt <= next_frame_cnt;
      hole_sel  <= next_hole_sel;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state     = state;
    next_depth     = depth;
    next_frame_cnt = frame_cnt;
    next_hole_sel  = hole_sel;
    case (state)
      IDLE: begin
        if (start_in) begin
          next_state     = APPROACH;
          next_depth     = START_DEPTH;
          next_frame_cnt = '0;
          next_hole_sel  = hole_sel_in;
        end
      end
      APPROACH: begin
        // Once the wall reaches the player the depth freezes for the rest of the round.
        if (depth <= player_depth_in) begin
          next_state = HIT;
        end else if (new_frame_in) begin
          if (frame_cnt == LAST_FRAME) begin
            next_frame_cnt = '0;
            next_depth     = sat_sub(depth, DEPTH_STEP);
          end else begin
            next_frame_cnt = frame_cnt + FW'(1);
          end
        end
      end
      HIT:     next_state = DONE;
      DONE:    if (new_frame_in) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign round_active = (state == APPROACH);
  assign wall_hit     = (state == HIT);
  assign wall_depth   = depth;

  hole_rect_t        rect, rect_d1;
  logic [HOLE_W-1:0] h_d1;
  logic [HOLE_H-1:0] v_d1;
  logic              active_d1;
  logic              in_hole;

  hole_rom u_hole_rom (
    .sel  (hole_sel),
    .rect (rect)
  );

  assign in_hole = (h_d1 >= rect_d1.x0) && (h_d1 < rect_d1.x1) &&
                   (v_d1 >= rect_d1.y0) && (v_d1 < rect_d1.y1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      h_d1       <= '0;
      v_d1       <= '0;
      rect_d1    <= '0;
      active_d1  <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      is_wall    <= 1'b0;
      wall_color <= '0;
    end else begin
      h_d1       <= h_count_in;
      v_d1       <= v_count_in;
      rect_d1    <= rect;
      active_d1  <= round_active;
      hcount_out <= h_d1;
      vcount_out <= v_d1;
      is_wall    <= active_d1 && (h_d1 < H_LIMIT) && (v_d1 < V_LIMIT) && !in_hole;
      wall_color <= depth[7] ? WALL_FAR_COLOR : WALL_NEAR_COLOR;
    end
  end

endmodule

// File: tb/tb_wall_generator.sv
// Bench for wall_generator: geometry vector table, directed round sequences and
// a randomized run compared cycle by cycle against an arithmetic reference model.
module tb_wall_generator;

  localparam int START = 255;
  localparam int STEP  = 2;
  localparam int SF    = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] h_in   = '0;
  logic [9:0]  v_in   = '0;
  logic        nf     = 1'b0;
  logic        st     = 1'b0;
  logic [1:0]  sel    = '0;
  logic [7:0]  pd     = '0;

  logic [10:0] hcount_out, d6_hcount_out;
  logic [9:0]  vcount_out, d6_vcount_out;
  logic        is_wall, d6_is_wall;
  logic [15:0] wall_color, d6_wall_color;
  logic [7:0]  wall_depth, d6_wall_depth;
  logic        round_active, d6_round_active;
  logic        wall_hit, d6_wall_hit;

  wall_generator dut (
    .clk_in(clk_in), .rst_in(rst_in), .h_count_in(h_in), .v_count_in(v_in),
    .new_frame_in(nf), .start_in(st), .hole_sel_in(sel), .player_depth_in(pd),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .is_wall(is_wall),
    .wall_color(wall_color), .wall_depth(wall_depth),
    .round_active(round_active), .wall_hit(wall_hit)
  );

  wall_generator #(.DEPTH_STEP(8'd200)) dut6 (
    .clk_in(clk_in), .rst_in(rst_in), .h_count_in(h_in), .v_count_in(v_in),
    .new_frame_in(nf), .start_in(st), .hole_sel_in(sel), .player_depth_in(pd),
    .hcount_out(d6_hcount_out), .vcount_out(d6_vcount_out), .is_wall(d6_is_wall),
    .wall_color(d6_wall_color), .wall_depth(d6_wall_depth),
    .round_active(d6_round_active), .wall_hit(d6_wall_hit)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Hole rectangles, half-open, indexed by hole select.
  int hx0[4] = '{512, 200, 560, 100};
  int hx1[4] = '{768, 1080, 720, 400};
  int hy0[4] = '{200, 500, 0, 100};
  int hy1[4] = '{520, 700, 720, 400};
  int h_edges[12] = '{0, 99, 100, 399, 400, 511, 512, 767, 768, 1079, 1279, 1280};
  int v_edges[10] = '{0, 99, 100, 199, 200, 519, 520, 699, 719, 720};

  typedef struct {
    int h;
    int v;
    bit wall;
  } pix_t;

  typedef struct {
    int sel;
    int h;
    int v;
    bit wall;
  } vec_t;

  // Reference model: round phase (0 idle, 1 approaching, 2 hit, 3 done),
  // frames seen since start, depth derived from that count.
  int   m_phase;
  int   m_depth;
  int   m_frames;
  int   m_sel;
  pix_t pipe0, pipe1;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit visible(bit ra, int s, int h, int v);
    bit hole;
    hole = (h >= hx0[s]) && (h < hx1[s]) && (v >= hy0[s]) && (v < hy1[s]);
    return ra && (h < 1280) && (v < 720) && !hole;
  endfunction

  task automatic reset_model();
    m_phase  = 0;
    m_depth  = 0;
    m_frames = 0;
    m_sel    = 0;
    pipe0    = '{0, 0, 1'b0};
    pipe1    = '{0, 0, 1'b0};
  endtask

  task automatic model_update();
    case (m_phase)
      0: if (st) begin
        m_phase  = 1;
        m_frames = 0;
        m_depth  = START;
        m_sel    = int'(sel);
      end
      1: if (m_depth <= int'(pd)) begin
        m_phase = 2;
      end else if (nf) begin
        m_frames++;
        m_depth = START - STEP * (m_frames / SF);
        if (m_depth < 0) m_depth = 0;
      end
      2: m_phase = 3;
      default: if (nf) m_phase = 0;
    endcase
  endtask

  // One clock: predict, advance, compare the primary DUT against the model.
  task automatic step();
    pix_t        p;
    logic [15:0] col;
    p.h  = int'(h_in);
    p.v  = int'(v_in);
    p.wall = visible(m_phase == 1, m_sel, p.h, p.v);
    col  = (m_depth < 128) ? 16'hF800 : 16'h7800;
    @(posedge clk_in);
    #1;
    model_update();
    pipe1 = pipe0;
    pipe0 = p;
    check("hcount_out", 32'(hcount_out), 32'(pipe1.h));
    check("vcount_out", 32'(vcount_out), 32'(pipe1.v));
    check("is_wall", 32'(is_wall), 32'(pipe1.wall));
    check("wall_color", 32'(wall_color), 32'(col));
    check("wall_depth", 32'(wall_depth), 32'(m_depth));
    check("round_active", 32'(round_active), 32'(m_phase == 1));
    check("wall_hit", 32'(wall_hit), 32'(m_phase == 2));
  endtask

  task automatic frame();
    nf = 1'b1;
    step();
    nf = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    check("rst hcount_out", 32'(hcount_out), 32'd0);
    check("rst vcount_out", 32'(vcount_out), 32'd0);
    check("rst is_wall", 32'(is_wall), 32'd0);
    check("rst wall_color", 32'(wall_color), 32'd0);
    check("rst wall_depth", 32'(wall_depth), 32'd0);
    check("rst round_active", 32'(round_active), 32'd0);
    check("rst wall_hit", 32'(wall_hit), 32'd0);
    check("rst d6 wall_depth", 32'(d6_wall_depth), 32'd0);
    reset_model();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic new_round(input int s, input logic [7:0] p);
    do_reset();
    pd  = p;
    sel = 2'(s);
    st  = 1'b1;
    step();
    st  = 1'b0;
  endtask

  task automatic add_vec(input int s, input int h, input int v, input bit w);
    vec_t e;
    e = '{s, h, v, w};
    vecs.push_back(e);
  endtask

  initial begin
    int cur;
    add_vec(0, 511, 300, 1'b1);  add_vec(0, 512, 300, 1'b0);
    add_vec(0, 767, 300, 1'b0);  add_vec(0, 768, 300, 1'b1);
    add_vec(0, 600, 199, 1'b1);  add_vec(0, 600, 200, 1'b0);
    add_vec(0, 600, 519, 1'b0);  add_vec(0, 600, 520, 1'b1);
    add_vec(0, 1279, 719, 1'b1); add_vec(0, 1280, 100, 1'b0);
    add_vec(0, 100, 720, 1'b0);  add_vec(0, 2047, 1023, 1'b0);
    add_vec(1, 200, 500, 1'b0);  add_vec(1, 1079, 699, 1'b0);
    add_vec(1, 1080, 699, 1'b1); add_vec(1, 600, 700, 1'b1);
    add_vec(2, 560, 0, 1'b0);    add_vec(2, 559, 0, 1'b1);
    add_vec(2, 719, 719, 1'b0);  add_vec(2, 720, 719, 1'b1);
    add_vec(3, 99, 100, 1'b1);   add_vec(3, 100, 100, 1'b0);
    add_vec(3, 399, 399, 1'b0);  add_vec(3, 400, 399, 1'b1);

    reset_model();
    #2;
    do_reset();
    step();
    check("post-reset round_active", 32'(round_active), 32'd0);
    check("post-reset is_wall", 32'(is_wall), 32'd0);

    // Start a round, then reset mid-stream.
    pd = 8'd0; st = 1'b1; step(); st = 1'b0;
    h_in = 11'd100; v_in = 10'd100;
    repeat (3) step();
    check("pre-reset is_wall", 32'(is_wall), 32'd1);
    do_reset();
    step();
    check("mid-reset idle", 32'(round_active), 32'd0);

    // Hole 0: centre pixel in the hole, corner pixel is wall, far colour.
    new_round(0, 8'd0);
    h_in = 11'd640; v_in = 10'd360;
    step(); step();
    check("t2 hcount", 32'(hcount_out), 32'd640);
    check("t2 hole is_wall", 32'(is_wall), 32'd0);
    h_in = 11'd100; v_in = 10'd100;
    step(); step();
    check("t2 wall is_wall", 32'(is_wall), 32'd1);
    check("t2 wall_color", 32'(wall_color), 32'h7800);

    // Geometry table.
    cur = -1;
    foreach (vecs[i]) begin
      if (vecs[i].sel != cur) begin
        new_round(vecs[i].sel, 8'd0);
        cur = vecs[i].sel;
      end
      h_in = 11'(vecs[i].h);
      v_in = 10'(vecs[i].v);
      step(); step();
      check($sformatf("vec%0d is_wall", i), 32'(is_wall), 32'(vecs[i].wall));
    end

    // Depth stepping and hit at player depth 250.
    new_round(0, 8'd250);
    repeat (3) frame();
    check("t3 depth after 3 frames", 32'(wall_depth), 32'd255);
    frame();
    check("t3 depth after 4 frames", 32'(wall_depth), 32'd253);
    repeat (2) step();
    check("t3 depth idle cycles", 32'(wall_depth), 32'd253);
    repeat (4) frame();
    check("t3 depth after 8 frames", 32'(wall_depth), 32'd251);
    check("t4 no hit at 251", 32'(wall_hit), 32'd0);
    repeat (3) frame();
    nf = 1'b1; step(); nf = 1'b0;
    check("t4 depth 249", 32'(wall_depth), 32'd249);
    check("t4 still active", 32'(round_active), 32'd1);
    step();
    check("t4 hit pulse", 32'(wall_hit), 32'd1);
    check("t4 round_active low", 32'(round_active), 32'd0);
    step();
    check("t4 hit one cycle", 32'(wall_hit), 32'd0);
    check("t4 depth held", 32'(wall_depth), 32'd249);
    frame();
    st = 1'b1; pd = 8'd0; step(); st = 1'b0;
    check("t4 back to idle then restart", 32'(wall_depth), 32'd255);

    // Start ignored during a round; start with new_frame in idle.
    new_round(0, 8'd0);
    repeat (4) frame();
    st = 1'b1; step(); st = 1'b0;
    check("t5 start ignored depth", 32'(wall_depth), 32'd253);
    check("t5 start ignored active", 32'(round_active), 32'd1);
    pd = 8'd255;
    repeat (2) step();
    frame();
    check("t5 idle", 32'(round_active), 32'd0);
    pd = 8'd0;
    st = 1'b1; nf = 1'b1; step(); st = 1'b0; nf = 1'b0;
    check("t5 start+frame depth", 32'(wall_depth), 32'd255);
    repeat (3) frame();
    check("t5 3 frames no step", 32'(wall_depth), 32'd255);
    frame();
    check("t5 4th frame steps", 32'(wall_depth), 32'd253);

    // Large step saturates to 0 and hits player depth 0.
    new_round(0, 8'd0);
    check("t6 start depth", 32'(d6_wall_depth), 32'd255);
    repeat (4) frame();
    check("t6 depth 55", 32'(d6_wall_depth), 32'd55);
    repeat (3) frame();
    check("t6 depth hold 55", 32'(d6_wall_depth), 32'd55);
    check("t6 no hit yet", 32'(d6_wall_hit), 32'd0);
    nf = 1'b1; step(); nf = 1'b0;
    check("t6 saturate 0", 32'(d6_wall_depth), 32'd0);
    step();
    check("t6 hit at 0", 32'(d6_wall_hit), 32'd1);
    step();
    check("t6 hit one cycle", 32'(d6_wall_hit), 32'd0);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      h_in = ($urandom_range(0, 3) == 0) ? 11'(h_edges[$urandom_range(0, 11)])
                                         : 11'($urandom_range(0, 1400));
      v_in = ($urandom_range(0, 3) == 0) ? 10'(v_edges[$urandom_range(0, 9)])
                                         : 10'($urandom_range(0, 800));
      nf  = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 15) == 0);
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0)
        pd = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 240));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
